// File: rtl/dma_apb_regs_if.sv
// APB3 bus bundle for the DMA register front-end.
interface dma_apb_regs_if #(
    parameter int unsigned ADDR_W = 12
) ();
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/dma_apb_regs.sv
// APB3 register front-end for the AHB DMA engine: staging, pending and active
// configuration sets, automatic launch of a queued transfer, sticky done IRQ.
module dma_apb_regs #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    dma_apb_regs_if.slave apb,
    output logic [31:0]   cfg_rd_addr,
    output logic [31:0]   cfg_wr_addr,
    output logic [31:0]   cfg_length,
    output logic [31:0]   cfg_step,
    output logic [1:0]    cfg_size,
    output logic          cfg_start,
    input  logic          dma_done,
    output logic          irq
);

    localparam logic [ADDR_W-1:0] ADDR_SRC    = ADDR_W'('h000);
    localparam logic [ADDR_W-1:0] ADDR_DST    = ADDR_W'('h004);
    localparam logic [ADDR_W-1:0] ADDR_LEN    = ADDR_W'('h008);
    localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'('h00C);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'('h010);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'('h014);
    localparam logic [ADDR_W-1:0] ADDR_INTCLR = ADDR_W'('h018);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state;
    // staging set and interrupt enable
    logic [31:0] src_q, dst_q, len_q, step_q;
    logic [1:0]  size_q;
    logic        ie_q;
    // pending set
    logic [31:0] pend_src, pend_dst, pend_len, pend_step;
    logic [1:0]  pend_size;
    logic        pend_valid;
    logic        done_flag;
    logic [CNT_W-1:0] done_cnt;

    logic        access, wr_en, rd_en, mapped;
    logic        ctrl_wr, start_wr, start_rej, start_ok, clr_wr, done_acc;
    logic [1:0]  size_stage;
    logic        ie_d, done_flag_d;
    logic [31:0] status;

    // Bus decode, START acceptance and next-state of the flag/IE bits
    always_comb begin
        access   = apb.PSEL & apb.PENABLE;
        wr_en    = access & apb.PWRITE;
        rd_en    = apb.PSEL & ~apb.PWRITE;
        mapped   = (apb.PADDR == ADDR_SRC)  || (apb.PADDR == ADDR_DST)    ||
                   (apb.PADDR == ADDR_LEN)  || (apb.PADDR == ADDR_STEP)   ||
                   (apb.PADDR == ADDR_CTRL) || (apb.PADDR == ADDR_STATUS) ||
                   (apb.PADDR == ADDR_INTCLR);
        ctrl_wr  = wr_en & (apb.PADDR == ADDR_CTRL);
        clr_wr   = wr_en & (apb.PADDR == ADDR_INTCLR) & apb.PWDATA[0];
        start_wr = ctrl_wr & apb.PWDATA[0];
        // The engine cannot finish in its own launch cycle
        done_acc = (state == StBusy) & dma_done & ~cfg_start;
        // A completion in the same cycle frees a slot, so no rejection then
        start_rej = start_wr & (state == StBusy) & pend_valid & ~done_acc;
        start_ok  = start_wr & ~start_rej;
        // Commit sees the SIZE written by the same CTRL access
        size_stage  = ctrl_wr ? apb.PWDATA[5:4] : size_q;
        ie_d        = ctrl_wr ? apb.PWDATA[8] : ie_q;
        done_flag_d = done_acc ? 1'b1 : (clr_wr ? 1'b0 : done_flag);
    end

    // Status word assembly
    always_comb begin
        status             = '0;
        status[0]          = (state == StBusy);
        status[1]          = pend_valid;
        status[2]          = done_flag;
        status[8 +: CNT_W] = done_cnt;
    end

    // Read mux and error response
    always_comb begin
        apb.PRDATA = '0;
        if (rd_en) begin
            case (apb.PADDR)
                ADDR_SRC:    apb.PRDATA = src_q;
                ADDR_DST:    apb.PRDATA = dst_q;
                ADDR_LEN:    apb.PRDATA = len_q;
                ADDR_STEP:   apb.PRDATA = step_q;
                ADDR_CTRL: begin
                    apb.PRDATA[5:4] = size_q;
                    apb.PRDATA[8]   = ie_q;
                end
                ADDR_STATUS: apb.PRDATA = status;
                default:     apb.PRDATA = '0;
            endcase
        end
        apb.PREADY  = 1'b1;
        apb.PSLVERR = access & (~mapped | start_rej);
    end

    // Staging registers and interrupt enable
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            step_q <= '0;
            size_q <= '0;
            ie_q   <= 1'b0;
        end else begin
            if (wr_en && apb.PADDR == ADDR_SRC)  src_q  <= apb.PWDATA;
            if (wr_en && apb.PADDR == ADDR_DST)  dst_q  <= apb.PWDATA;
            if (wr_en && apb.PADDR == ADDR_LEN)  len_q  <= apb.PWDATA;
            if (wr_en && apb.PADDR == ADDR_STEP) step_q <= apb.PWDATA;
            size_q <= size_stage;
            ie_q   <= ie_d;
        end
    end

    // Launch FSM: active/pending sets, start pulse, completion bookkeeping
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= StIdle;
            cfg_rd_addr <= '0;
            cfg_wr_addr <= '0;
            cfg_length  <= '0;
            cfg_step    <= '0;
            cfg_size    <= '0;
            cfg_start   <= 1'b0;
            pend_src    <= '0;
            pend_dst    <= '0;
            pend_len    <= '0;
            pend_step   <= '0;
            pend_size   <= '0;
            pend_valid  <= 1'b0;
            done_flag   <= 1'b0;
            done_cnt    <= '0;
            irq         <= 1'b0;
        end else begin
            cfg_start <= 1'b0;
            done_flag <= done_flag_d;
            irq       <= done_flag_d & ie_d;
            if (done_acc && done_cnt != CNT_MAX) begin
                done_cnt <= done_cnt + 1'b1;
            end
            case (state)
                StIdle: begin
                    if (start_ok) begin
                        cfg_rd_addr <= src_q;
                        cfg_wr_addr <= dst_q;
                        cfg_length  <= len_q;
                        cfg_step    <= step_q;
                        cfg_size    <= size_stage;
                        cfg_start   <= 1'b1;
                        state       <= StBusy;
                    end
                end
                StBusy: begin
                    if (done_acc && pend_valid) begin
                        cfg_rd_addr <= pend_src;
                        cfg_wr_addr <= pend_dst;
                        cfg_length  <= pend_len;
                        cfg_step    <= pend_step;
                        cfg_size    <= pend_size;
                        cfg_start   <= 1'b1;
                        pend_valid  <= start_ok;
                    end else if (done_acc && start_ok) begin
                        cfg_rd_addr <= src_q;
                        cfg_wr_addr <= dst_q;
                        cfg_length  <= len_q;
                        cfg_step    <= step_q;
                        cfg_size    <= size_stage;
                        cfg_start   <= 1'b1;
                    end else if (done_acc) begin
                        state <= StIdle;
                    end
                    // Staging goes to pending whenever it is not launched directly
                    if (start_ok && (pend_valid || !done_acc)) begin
                        pend_src   <= src_q;
                        pend_dst   <= dst_q;
                        pend_len   <= len_q;
                        pend_step  <= step_q;
                        pend_size  <= size_stage;
                        pend_valid <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
